mem_access_stage: RTL

- Pipeline stage between execute and write-back.
- Takes the registered execute result (ALU value, rd, store data, load/store decode) and performs the data-memory access.
- Memory port uses a req/ready handshake; the stage stalls upstream while an access is outstanding.
- Produces the final rd value and write-enable consumed by the write stage and register bank.

---
 rtl/mem_access_stage.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives a req/ready data-memory port for loads/stores, stalls upstream while busy.
// Optional build macro MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of ignoring low address bits.
module mem_access_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_rs2_v,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [2:0]      in_funct3,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_wen,
  output logic            err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            load_q, load_d;

  logic            stall_d, req_d, we_d, ov_d, wen_d, err_d;
  logic [XLEN-1:0] addr_d, wdata_d, odata_d;
  logic [3:0]      wstrb_d;
  logic [4:0]      ord_d;

  logic            is_mem_c, misalign_c;
  logic [7:0]      byte_c;
  logic [15:0]     half_c;
  logic [XLEN-1:0] load_c, st_data_c;
  logic [3:0]      st_strb_c;

  assign is_mem_c = in_is_load || in_is_store;

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = (in_funct3[1:0] == 2'b01 && in_alu[0]) ||
                      (in_funct3[1] && in_alu[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Store byte-lane replication and strobes; funct3[1:0] selects byte/half/word
  always_comb begin
    st_strb_c = 4'b1111;
    st_data_c = in_rs2_v;
    case (in_funct3[1:0])
      2'b00: begin
        st_strb_c = 4'b0001 << in_alu[1:0];
        st_data_c = {(XLEN/8){in_rs2_v[7:0]}};
      end
      2'b01: begin
        st_strb_c = in_alu[1] ? 4'b1100 : 4'b0011;
        st_data_c = {(XLEN/16){in_rs2_v[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension; unknown funct3 falls back to a full word
  always_comb begin
    byte_c = 8'(mem_rdata >> {off_q, 3'b000});
    half_c = 16'(mem_rdata >> {off_q[1], 4'b0000});
    case (f3_q)
      3'b000:  load_c = {{(XLEN-8){byte_c[7]}}, byte_c};
      3'b100:  load_c = {{(XLEN-8){1'b0}}, byte_c};
      3'b001:  load_c = {{(XLEN-16){half_c[15]}}, half_c};
      3'b101:  load_c = {{(XLEN-16){1'b0}}, half_c};
      default: load_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    off_d   = off_q;
    load_d  = load_q;
    stall_d = stall;
    req_d   = mem_req;
    we_d    = mem_we;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    wstrb_d = mem_wstrb;
    ov_d    = 1'b0;
    ord_d   = out_rd;
    odata_d = out_data;
    wen_d   = out_wen;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem_c) begin
            ov_d    = 1'b1;
            ord_d   = in_rd;
            odata_d = in_alu;
            wen_d   = (in_rd != 5'd0);
          end else if (misalign_c) begin
            ov_d    = 1'b1;
            err_d   = 1'b1;
            ord_d   = in_rd;
            odata_d = '0;
            wen_d   = 1'b0;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
            rd_d    = in_rd;
            f3_d    = in_funct3;
            off_d   = in_alu[1:0];
            load_d  = in_is_load;
            stall_d = 1'b1;
            req_d   = 1'b1;
            we_d    = in_is_store && !in_is_load;
            addr_d  = {in_alu[XLEN-1:2], 2'b00};
            wdata_d = in_is_load ? '0 : st_data_c;
            wstrb_d = in_is_load ? 4'b0000 : st_strb_c;
          end
        end
      end
      ACCESS: begin
        if (mem_ready || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          stall_d = 1'b0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          ov_d    = 1'b1;
          ord_d   = rd_q;
          err_d   = !mem_ready;
          wen_d   = mem_ready && load_q && (rd_q != 5'd0);
          odata_d = (mem_ready && load_q) ? load_c : '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      load_q    <= 1'b0;
      stall     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_data  <= '0;
      out_wen   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      load_q    <= load_d;
      stall     <= stall_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_wstrb <= wstrb_d;
      out_valid <= ov_d;
      out_rd    <= ord_d;
      out_data  <= odata_d;
      out_wen   <= wen_d;
      err       <= err_d;
    end
  end

endmodule
